// File: rtl/apu_buf_pkg.sv
// apu_buf_pkg: default widths and payload types shared by the APU request buffer.
package apu_buf_pkg;
    localparam int NARGS_DEF    = 3;
    localparam int WOP_DEF      = 6;
    localparam int NDSFLAGS_DEF = 15;
    localparam int NUSFLAGS_DEF = 6;

    typedef struct packed {
        logic [NARGS_DEF-1:0][31:0] operands;
        logic [WOP_DEF-1:0]         op;
        logic [NDSFLAGS_DEF-1:0]    flags;
    } apu_req_t;

    typedef struct packed {
        logic [31:0]             result;
        logic [NUSFLAGS_DEF-1:0] flags;
    } apu_rsp_t;
endpackage

// File: rtl/apu_buf_fifo.sv
// apu_buf_fifo: synchronous FIFO with registered storage, head always visible.
module apu_buf_fifo
    import apu_buf_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = apu_req_t
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output T                       head
);
    localparam int AW = $clog2(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/apu_req_buffer.sv
// apu_req_buffer: elastic request FIFO between the core APU port and the accelerator,
// with an in-flight cap and a registered in-order response path.
module apu_req_buffer
    import apu_buf_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int NARGS           = NARGS_DEF,
    parameter int WOP             = WOP_DEF,
    parameter int NDSFLAGS        = NDSFLAGS_DEF,
    parameter int NUSFLAGS        = NUSFLAGS_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       apu_req_i,
    output logic                       apu_gnt_o,
    input  logic [NARGS-1:0][31:0]     apu_operands_i,
    input  logic [WOP-1:0]             apu_op_i,
    input  logic [NDSFLAGS-1:0]        apu_flags_i,
    output logic                       apu_rvalid_o,
    output logic [31:0]                apu_result_o,
    output logic [NUSFLAGS-1:0]        apu_flags_o,
    output logic                       acc_req_o,
    input  logic                       acc_gnt_i,
    output logic [NARGS-1:0][31:0]     acc_operands_o,
    output logic [WOP-1:0]             acc_op_o,
    output logic [NDSFLAGS-1:0]        acc_flags_o,
    input  logic                       acc_rvalid_i,
    input  logic [31:0]                acc_result_i,
    input  logic [NUSFLAGS-1:0]        acc_flags_i,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output logic [3:0]                 outstanding_o,
    output logic                       err_o
);
    typedef struct packed {
        logic [NARGS-1:0][31:0] operands;
        logic [WOP-1:0]         op;
        logic [NDSFLAGS-1:0]    flags;
    } req_t;

    req_t din, head;
    logic full, empty, pop;

    assign din       = '{operands: apu_operands_i, op: apu_op_i, flags: apu_flags_i};
    assign apu_gnt_o = apu_req_i && !full;
    assign acc_req_o = !empty && (outstanding_o < 4'(MAX_OUTSTANDING));
    assign pop       = acc_req_o && acc_gnt_i;
    assign {acc_operands_o, acc_op_o, acc_flags_o} = head;

    apu_buf_fifo #(.DEPTH(DEPTH), .T(req_t)) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (apu_gnt_o),
        .pop    (pop),
        .din    (din),
        .full   (full),
        .empty  (empty),
        .count  (occupancy_o),
        .head   (head)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_o <= '0;
            apu_rvalid_o  <= 1'b0;
            apu_result_o  <= '0;
            apu_flags_o   <= '0;
            err_o         <= 1'b0;
        end else begin
            // A response with nothing in flight is flagged but still forwarded.
            outstanding_o <= pop && !acc_rvalid_i ? outstanding_o + 4'd1 :
                             !pop && acc_rvalid_i && outstanding_o != '0 ? outstanding_o - 4'd1 :
                             outstanding_o;
            err_o         <= acc_rvalid_i && !pop && outstanding_o == '0;
            apu_rvalid_o  <= acc_rvalid_i;
            if (acc_rvalid_i) begin
                apu_result_o <= acc_result_i;
                apu_flags_o  <= acc_flags_i;
            end
        end
    end
endmodule

// File: tb/tb_apu_req_buffer.sv
// tb_apu_req_buffer: directed and random stimulus checked against a queue-based model.
module tb_apu_req_buffer;
    import apu_buf_pkg::*;
    localparam int DEPTH = 4, MAXO = 2;
    localparam int NA = NARGS_DEF, W = WOP_DEF, ND = NDSFLAGS_DEF, NU = NUSFLAGS_DEF;

    logic                   clk_i = 1'b0, rst_ni = 1'b0;
    logic                   apu_req_i = 1'b0, apu_gnt_o;
    logic [NA-1:0][31:0]    apu_operands_i = '0;
    logic [W-1:0]           apu_op_i = '0;
    logic [ND-1:0]          apu_flags_i = '0;
    logic                   apu_rvalid_o;
    logic [31:0]            apu_result_o;
    logic [NU-1:0]          apu_flags_o;
    logic                   acc_req_o, acc_gnt_i = 1'b0;
    logic [NA-1:0][31:0]    acc_operands_o;
    logic [W-1:0]           acc_op_o;
    logic [ND-1:0]          acc_flags_o;
    logic                   acc_rvalid_i = 1'b0;
    logic [31:0]            acc_result_i = '0;
    logic [NU-1:0]          acc_flags_i = '0;
    logic [$clog2(DEPTH):0] occupancy_o;
    logic [3:0]             outstanding_o;
    logic                   err_o;

    apu_req_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .apu_req_i(apu_req_i), .apu_gnt_o(apu_gnt_o), .apu_operands_i(apu_operands_i),
        .apu_op_i(apu_op_i), .apu_flags_i(apu_flags_i), .apu_rvalid_o(apu_rvalid_o),
        .apu_result_o(apu_result_o), .apu_flags_o(apu_flags_o),
        .acc_req_o(acc_req_o), .acc_gnt_i(acc_gnt_i), .acc_operands_o(acc_operands_o),
        .acc_op_o(acc_op_o), .acc_flags_o(acc_flags_o), .acc_rvalid_i(acc_rvalid_i),
        .acc_result_i(acc_result_i), .acc_flags_i(acc_flags_i),
        .occupancy_o(occupancy_o), .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    apu_req_t    q[$];
    apu_req_t    popped[$];
    int          m_out = 0, n_cmp = 0, n_bad = 0;
    logic        m_rv = 1'b0, m_err = 1'b0, last_push = 1'b0;
    logic [31:0] m_res = '0;
    logic [NU-1:0] m_fl = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_out = 0; m_rv = 1'b0; m_err = 1'b0; m_res = '0; m_fl = '0;
    endtask

    task automatic check_outputs();
        chk("gnt", apu_gnt_o, apu_req_i && q.size() != DEPTH);
        chk("acc_req", acc_req_o, q.size() != 0 && m_out < MAXO);
        chk("occupancy", occupancy_o, q.size());
        chk("outstanding", outstanding_o, m_out);
        chk("rvalid", apu_rvalid_o, m_rv);
        chk("result", apu_result_o, m_res);
        chk("rflags", apu_flags_o, m_fl);
        chk("err", err_o, m_err);
        if (q.size() != 0) chk("head", {acc_operands_o, acc_op_o, acc_flags_o}, q[0]);
    endtask

    task automatic model_edge();
        logic pop;
        apu_req_t r;
        last_push = apu_req_i && q.size() != DEPTH;
        pop = q.size() != 0 && m_out < MAXO && acc_gnt_i;
        if (pop) begin
            popped.push_back(q[0]);
            void'(q.pop_front());
        end
        if (last_push) begin
            r.operands = apu_operands_i; r.op = apu_op_i; r.flags = apu_flags_i;
            q.push_back(r);
        end
        m_err = acc_rvalid_i && !pop && m_out == 0;
        if (pop && !acc_rvalid_i) m_out++;
        else if (!pop && acc_rvalid_i && m_out > 0) m_out--;
        m_rv = acc_rvalid_i;
        if (acc_rvalid_i) begin
            m_res = acc_result_i;
            m_fl = acc_flags_i;
        end
    endtask

    task automatic step();
        #1;
        check_outputs();
        model_edge();
        @(negedge clk_i);
    endtask

    task automatic rand_req();
        apu_operands_i = {$urandom, $urandom, $urandom};
        apu_op_i = W'($urandom);
        apu_flags_i = ND'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        apu_req_i = 1'b0;
        acc_gnt_i = 1'b1;
        while ((q.size() != 0 || m_out != 0) && n < 50) begin
            acc_rvalid_i = m_out > 0;
            acc_result_i = $urandom;
            acc_flags_i = NU'($urandom);
            step();
            n++;
        end
        acc_gnt_i = 1'b0;
        acc_rvalid_i = 1'b0;
        chk("drain_bound", n < 50, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        chk("rst_gnt_req", {apu_gnt_o, acc_req_o, apu_rvalid_o, err_o}, 0);
        chk("rst_counts", {occupancy_o, outstanding_o}, 0);
        chk("rst_rsp", {apu_result_o, apu_flags_o}, 0);
        chk("rst_payload", {acc_operands_o, acc_op_o, acc_flags_o}, 0);
        rst_ni = 1'b1;
        model_reset();

        // single op
        apu_req_i = 1'b1; apu_op_i = 6'h0A;
        apu_operands_i[0] = 32'd1; apu_operands_i[1] = 32'd2; apu_operands_i[2] = 32'd3;
        #1 chk("single_gnt", apu_gnt_o, 1);
        step();
        chk("single_acc_req", acc_req_o, 1);
        chk("single_op", acc_op_o, 6'h0A);
        apu_req_i = 1'b0; acc_gnt_i = 1'b1;
        step();
        acc_gnt_i = 1'b0;
        step();
        acc_rvalid_i = 1'b1; acc_result_i = 32'h5;
        step();
        acc_rvalid_i = 1'b0;
        chk("single_rvalid", apu_rvalid_o, 1);
        chk("single_result", apu_result_o, 32'h5);
        chk("single_out", outstanding_o, 0);
        step();
        chk("single_hold", apu_result_o, 32'h5);

        // fill until full, fifth request waits for a pop
        for (int i = 0; i < 4; i++) begin
            apu_req_i = 1'b1; rand_req();
            step();
        end
        chk("full_occ", occupancy_o, 4);
        rand_req();
        #1 chk("full_nogrant", apu_gnt_o, 0);
        acc_gnt_i = 1'b1;
        step();
        acc_gnt_i = 1'b0;
        #1 chk("full_grant_after_pop", apu_gnt_o, 1);
        step();
        chk("full_occ2", occupancy_o, 4);
        drain();

        // outstanding cap
        for (int i = 0; i < 4; i++) begin
            apu_req_i = 1'b1; rand_req();
            step();
        end
        apu_req_i = 1'b0; acc_gnt_i = 1'b1;
        repeat (4) step();
        chk("cap_occ", occupancy_o, 2);
        chk("cap_out", outstanding_o, MAXO);
        chk("cap_acc_req", acc_req_o, 0);
        acc_rvalid_i = 1'b1;
        step();
        acc_rvalid_i = 1'b0;
        chk("cap_reassert", acc_req_o, 1);

        // simultaneous push, pop and response
        chk("sim_pre", {occupancy_o, outstanding_o}, {3'd2, 4'd1});
        apu_req_i = 1'b1; rand_req(); acc_rvalid_i = 1'b1;
        step();
        acc_rvalid_i = 1'b0;
        chk("sim_occ", occupancy_o, 2);
        chk("sim_out", outstanding_o, 1);
        drain();

        // ordering across pointer wrap
        popped.delete();
        for (int i = 0; i < 8; i++) begin
            apu_req_i = 1'b1; rand_req(); apu_op_i = W'(i);
            acc_gnt_i = 1'b1; acc_rvalid_i = m_out > 0;
            step();
        end
        drain();
        chk("order_count", popped.size(), 8);
        for (int k = 0; k < popped.size(); k++) chk("order_op", popped[k].op, k);

        // spurious response
        acc_rvalid_i = 1'b1; acc_result_i = 32'hDEAD_BEEF;
        step();
        acc_rvalid_i = 1'b0;
        chk("spur_err", err_o, 1);
        chk("spur_out", outstanding_o, 0);
        chk("spur_rvalid", apu_rvalid_o, 1);
        step();
        chk("spur_err_clear", err_o, 0);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            if (!apu_req_i || last_push) begin
                apu_req_i = $urandom_range(0, 3) != 0;
                rand_req();
            end
            acc_gnt_i = $urandom_range(0, 2) != 0;
            acc_rvalid_i = m_out > 0 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 15) == 0;
            acc_result_i = $urandom;
            acc_flags_i = NU'($urandom);
            step();
        end
        drain();

        // reset mid-flight
        for (int i = 0; i < 4; i++) begin
            apu_req_i = 1'b1; rand_req();
            step();
        end
        apu_req_i = 1'b0; acc_gnt_i = 1'b1;
        step();
        acc_gnt_i = 1'b0;
        chk("mid_pre", {occupancy_o, outstanding_o}, {3'd3, 4'd1});
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_ctl", {apu_gnt_o, acc_req_o, apu_rvalid_o, err_o}, 0);
        chk("mid_rst_counts", {occupancy_o, outstanding_o}, 0);
        chk("mid_rst_rsp", {apu_result_o, apu_flags_o}, 0);
        chk("mid_rst_payload", {acc_operands_o, acc_op_o, acc_flags_o}, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        step();
        acc_rvalid_i = 1'b1;
        step();
        acc_rvalid_i = 1'b0;
        chk("post_rst_err", err_o, 1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
